// File: rtl/video_timing_pkg.sv
// Shared timing descriptors, standard mode constants and FSM state type
// for the raster timing generator.
package video_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        h_pol;
    logic        v_pol;
  } timing_t;

  localparam timing_t SVGA_800X600_56 = '{
    h_active: 800, h_fp: 24, h_sync: 72, h_bp: 128,
    v_active: 600, v_fp: 1,  v_sync: 2,  v_bp: 22,
    h_pol: 1'b1, v_pol: 1'b1
  };

  localparam timing_t VGA_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    h_pol: 1'b0, v_pol: 1'b0
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register with per-bit reset value; depth 0 is a wire.
module sig_delay #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        stage_q <= {DEPTH{RST_VAL}};
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: h/v counters, syncs, display enable,
// line/frame strobes, frame counter and a delayed copy of sync/enable.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = SVGA_800X600_56.h_active,
  parameter int unsigned H_FP        = SVGA_800X600_56.h_fp,
  parameter int unsigned H_SYNC      = SVGA_800X600_56.h_sync,
  parameter int unsigned H_BP        = SVGA_800X600_56.h_bp,
  parameter int unsigned V_ACTIVE    = SVGA_800X600_56.v_active,
  parameter int unsigned V_FP        = SVGA_800X600_56.v_fp,
  parameter int unsigned V_SYNC      = SVGA_800X600_56.v_sync,
  parameter int unsigned V_BP        = SVGA_800X600_56.v_bp,
  parameter bit          H_SYNC_POL  = SVGA_800X600_56.h_pol,
  parameter bit          V_SYNC_POL  = SVGA_800X600_56.v_pol,
  parameter int unsigned DELAY       = 0,
  parameter int unsigned FRAME_CNT_W = 16,
  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned H_W        = $clog2(H_TOTAL),
  localparam int unsigned V_W        = $clog2(V_TOTAL)
) (
  input  logic                   pixel_clk,
  input  logic                   arst,
  input  logic                   en,
  output logic [H_W-1:0]         h_coord,
  output logic [V_W-1:0]         v_coord,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   disp_enbl,
  output logic                   h_sync_d,
  output logic                   v_sync_d,
  output logic                   disp_enbl_d,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   running
);

  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  state_e                 state_q, state_d;
  logic [H_W-1:0]         h_q, h_d;
  logic [V_W-1:0]         v_q, v_d;
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
  logic                   hs_q, vs_q, de_q, ls_q, fs_q;
  logic                   hs_d, vs_d, de_d, ls_d, fs_d;
  logic                   run_d, h_last, v_last;

  assign h_last = (32'(h_q) == H_TOTAL - 1);
  assign v_last = (32'(v_q) == V_TOTAL - 1);

  always_comb begin
    state_d = state_q;
    h_d     = '0;
    v_d     = '0;
    fcnt_d  = fcnt_q;
    if (state_q == ST_IDLE) begin
      if (en) state_d = ST_RUN;
    end else begin
      h_d = h_q + H_W'(1);
      v_d = v_q;
      if (h_last) begin
        h_d = '0;
        v_d = v_q + V_W'(1);
        if (v_last) begin
          // en is only honoured here, so a stop never truncates a frame
          v_d    = '0;
          fcnt_d = fcnt_q + FRAME_CNT_W'(1);
          if (!en) state_d = ST_IDLE;
        end
      end
    end

    // Decode from the next count so registered outputs line up with the coords
    run_d = (state_d == ST_RUN);
    de_d  = run_d && (32'(h_d) < H_ACTIVE) && (32'(v_d) < V_ACTIVE);
    hs_d  = (run_d && (32'(h_d) >= HS_START) && (32'(h_d) < HS_END)) ?
            H_SYNC_POL : !H_SYNC_POL;
    vs_d  = (run_d && (32'(v_d) >= VS_START) && (32'(v_d) < VS_END)) ?
            V_SYNC_POL : !V_SYNC_POL;
    ls_d  = run_d && (h_d == '0);
    fs_d  = run_d && (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge pixel_clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      fcnt_q  <= '0;
      hs_q    <= !H_SYNC_POL;
      vs_q    <= !V_SYNC_POL;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fcnt_q  <= fcnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  sig_delay #(
    .WIDTH   (3),
    .DEPTH   (DELAY),
    .RST_VAL ({!H_SYNC_POL, !V_SYNC_POL, 1'b0})
  ) u_delay (
    .clk_i (pixel_clk),
    .rst_i (arst),
    .d_i   ({hs_q, vs_q, de_q}),
    .q_o   ({h_sync_d, v_sync_d, disp_enbl_d})
  );

  assign h_coord     = h_q;
  assign v_coord     = v_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign disp_enbl   = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fcnt_q;
  assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;
  import video_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic arst_m, arst_b, en_m, en_b;

  logic [3:0] m_h, m_v, m_fc;
  logic m_hs, m_vs, m_de, m_hsd, m_vsd, m_ded, m_ls, m_fs, m_run;
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .DELAY(0), .FRAME_CNT_W(4)
  ) u_m (
    .pixel_clk(clk), .arst(arst_m), .en(en_m),
    .h_coord(m_h), .v_coord(m_v), .h_sync(m_hs), .v_sync(m_vs),
    .disp_enbl(m_de), .h_sync_d(m_hsd), .v_sync_d(m_vsd),
    .disp_enbl_d(m_ded), .line_start(m_ls), .frame_start(m_fs),
    .frame_cnt(m_fc), .running(m_run)
  );

  logic [9:0] g_h, g_v;
  logic [15:0] g_fc;
  logic g_hs, g_vs, g_de, g_hsd, g_vsd, g_ded, g_ls, g_fs, g_run;
  video_timing_gen #(
    .H_ACTIVE(VGA_640X480_60.h_active), .H_FP(VGA_640X480_60.h_fp),
    .H_SYNC(VGA_640X480_60.h_sync), .H_BP(VGA_640X480_60.h_bp),
    .V_ACTIVE(VGA_640X480_60.v_active), .V_FP(VGA_640X480_60.v_fp),
    .V_SYNC(VGA_640X480_60.v_sync), .V_BP(VGA_640X480_60.v_bp),
    .H_SYNC_POL(VGA_640X480_60.h_pol), .V_SYNC_POL(VGA_640X480_60.v_pol),
    .DELAY(3), .FRAME_CNT_W(16)
  ) u_g (
    .pixel_clk(clk), .arst(arst_b), .en(en_b),
    .h_coord(g_h), .v_coord(g_v), .h_sync(g_hs), .v_sync(g_vs),
    .disp_enbl(g_de), .h_sync_d(g_hsd), .v_sync_d(g_vsd),
    .disp_enbl_d(g_ded), .line_start(g_ls), .frame_start(g_fs),
    .frame_cnt(g_fc), .running(g_run)
  );

  logic [1:0] n_h, n_v, n_fc;
  logic n_hs, n_vs, n_de, n_hsd, n_vsd, n_ded, n_ls, n_fs, n_run;
  video_timing_gen #(
    .H_ACTIVE(2), .H_FP(0), .H_SYNC(1), .H_BP(0),
    .V_ACTIVE(2), .V_FP(0), .V_SYNC(1), .V_BP(0),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .DELAY(0), .FRAME_CNT_W(2)
  ) u_n (
    .pixel_clk(clk), .arst(arst_b), .en(en_b),
    .h_coord(n_h), .v_coord(n_v), .h_sync(n_hs), .v_sync(n_vs),
    .disp_enbl(n_de), .h_sync_d(n_hsd), .v_sync_d(n_vsd),
    .disp_enbl_d(n_ded), .line_start(n_ls), .frame_start(n_fs),
    .frame_cnt(n_fc), .running(n_run)
  );

  localparam int M_H = 0, M_V = 1, M_HS = 2, M_VS = 3, M_DE = 4, M_LS = 5,
                 M_FS = 6, M_FC = 7, M_RUN = 8, M_HSD = 9, M_VSD = 10;
  localparam int G_HS = 20, G_HSD = 21, G_DE = 22, G_DED = 23, G_FS = 24;
  localparam int N_H = 30, N_V = 31, N_HS = 32, N_VS = 33, N_FC = 34, N_FS = 35;

  typedef struct {
    int    at;
    int    sig;
    int    val;
    string name;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic int sample(input int sig);
    case (sig)
      M_H:   return int'(m_h);
      M_V:   return int'(m_v);
      M_HS:  return int'(m_hs);
      M_VS:  return int'(m_vs);
      M_DE:  return int'(m_de);
      M_LS:  return int'(m_ls);
      M_FS:  return int'(m_fs);
      M_FC:  return int'(m_fc);
      M_RUN: return int'(m_run);
      M_HSD: return int'(m_hsd);
      M_VSD: return int'(m_vsd);
      G_HS:  return int'(g_hs);
      G_HSD: return int'(g_hsd);
      G_DE:  return int'(g_de);
      G_DED: return int'(g_ded);
      G_FS:  return int'(g_fs);
      N_H:   return int'(n_h);
      N_V:   return int'(n_v);
      N_HS:  return int'(n_hs);
      N_VS:  return int'(n_vs);
      N_FC:  return int'(n_fc);
      N_FS:  return int'(n_fs);
      default: return -1;
    endcase
  endfunction

  task automatic expect_at(input int at, input int sig, input int val, input string name);
    sb.push_back('{at, sig, val, name});
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        checks++;
        if (sample(sb[i].sig) != sb[i].val) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                   sb[i].name, cyc, sample(sb[i].sig), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step(1);
  endtask

  initial begin
    arst_m = 1'b1; arst_b = 1'b1; en_m = 1'b0; en_b = 1'b0;
    step(1);
    checks++;
    if (m_h !== 4'd0) begin
      errors++; $display("FAIL direct_rst_h: got %0d", m_h);
    end
    checks++;
    if (m_run !== 1'b0) begin
      errors++; $display("FAIL direct_rst_run: got %0b", m_run);
    end
    checks++;
    if (g_hsd !== 1'b1) begin
      errors++; $display("FAIL direct_rst_vga_hsd: got %0b", g_hsd);
    end
    expect_at(1, M_H, 0, "rst_h");    expect_at(1, M_V, 0, "rst_v");
    expect_at(1, M_HS, 0, "rst_hs");  expect_at(1, M_VS, 0, "rst_vs");
    expect_at(1, M_DE, 0, "rst_de");  expect_at(1, M_LS, 0, "rst_ls");
    expect_at(1, M_FS, 0, "rst_fs");  expect_at(1, M_FC, 0, "rst_fc");
    expect_at(1, M_RUN, 0, "rst_run");
    expect_at(1, G_HSD, 1, "rst_vga_hsd"); expect_at(1, G_DED, 0, "rst_vga_ded");
    expect_at(1, N_FC, 0, "rst_min_fc");

    arst_m = 1'b0; arst_b = 1'b0; en_m = 1'b1; en_b = 1'b1;

    expect_at(2, M_FS, 1, "fs_first"); expect_at(2, M_H, 0, "first_h");
    expect_at(2, M_V, 0, "first_v");   expect_at(2, M_RUN, 1, "first_run");
    expect_at(2, M_DE, 1, "first_de"); expect_at(2, M_LS, 1, "first_ls");
    expect_at(9, M_DE, 1, "de_h7");    expect_at(10, M_DE, 0, "de_h8");
    expect_at(11, M_HS, 0, "hs_h9");   expect_at(12, M_HS, 1, "hs_h10");
    expect_at(12, M_HSD, 1, "hsd_pass"); expect_at(14, M_HS, 1, "hs_h12");
    expect_at(15, M_HS, 0, "hs_h13");
    expect_at(18, M_LS, 1, "ls_line1"); expect_at(18, M_H, 0, "h_wrap");
    expect_at(18, M_V, 1, "v_inc");     expect_at(18, M_FS, 0, "fs_line1");
    expect_at(98, M_DE, 0, "de_v6");
    expect_at(113, M_VS, 0, "vs_v6");  expect_at(114, M_VS, 1, "vs_v7");
    expect_at(114, M_VSD, 1, "vsd_pass");
    expect_at(145, M_VS, 1, "vs_v8");  expect_at(146, M_VS, 0, "vs_v9");
    expect_at(193, M_H, 15, "last_h"); expect_at(193, M_V, 11, "last_v");
    expect_at(193, M_FC, 0, "fc_f1_end");
    expect_at(194, M_FS, 1, "fs_f2"); expect_at(194, M_FC, 1, "fc_f2");
    expect_at(194, M_H, 0, "f2_h");   expect_at(194, M_V, 0, "f2_v");
    expect_at(385, M_H, 15, "stop_last_h"); expect_at(385, M_V, 11, "stop_last_v");
    expect_at(385, M_RUN, 1, "stop_last_run");
    expect_at(386, M_RUN, 0, "idle_run"); expect_at(386, M_H, 0, "idle_h");
    expect_at(386, M_V, 0, "idle_v");     expect_at(386, M_FC, 2, "idle_fc");
    expect_at(386, M_FS, 0, "idle_fs");
    expect_at(390, M_LS, 0, "idle_ls");   expect_at(390, M_RUN, 0, "idle_run2");
    expect_at(400, M_FS, 0, "idle_fs2");
    expect_at(401, M_FS, 1, "restart_fs"); expect_at(401, M_RUN, 1, "restart_run");
    expect_at(401, M_FC, 2, "restart_fc");
    expect_at(592, M_RUN, 1, "pulse_run"); expect_at(592, M_H, 15, "pulse_h");
    expect_at(593, M_FS, 1, "pulse_fs");   expect_at(593, M_FC, 3, "pulse_fc");
    expect_at(593, M_RUN, 1, "pulse_run2");
    expect_at(682, M_H, 9, "pre_rst_h");   expect_at(682, M_V, 5, "pre_rst_v");

    expect_at(2, G_FS, 1, "vga_fs");
    expect_at(4, G_DED, 0, "vga_ded_b2"); expect_at(5, G_DED, 1, "vga_ded_b3");
    expect_at(641, G_DE, 1, "vga_de_h639"); expect_at(642, G_DE, 0, "vga_de_h640");
    expect_at(644, G_DED, 1, "vga_ded_h639"); expect_at(645, G_DED, 0, "vga_ded_h640");
    expect_at(657, G_HS, 1, "vga_hs_h655"); expect_at(658, G_HS, 0, "vga_hs_h656");
    expect_at(753, G_HS, 0, "vga_hs_h751"); expect_at(754, G_HS, 1, "vga_hs_h752");
    expect_at(660, G_HSD, 1, "vga_hsd_h655"); expect_at(661, G_HSD, 0, "vga_hsd_h656");
    expect_at(756, G_HSD, 0, "vga_hsd_h751"); expect_at(757, G_HSD, 1, "vga_hsd_h752");

    expect_at(2, N_FS, 1, "min_fs");  expect_at(2, N_H, 0, "min_h0");
    expect_at(2, N_V, 0, "min_v0");
    expect_at(3, N_H, 1, "min_h1");   expect_at(3, N_HS, 0, "min_hs_h1");
    expect_at(4, N_H, 2, "min_h2");   expect_at(4, N_HS, 1, "min_hs_h2");
    expect_at(5, N_H, 0, "min_hwrap"); expect_at(5, N_V, 1, "min_v1");
    expect_at(5, N_HS, 0, "min_hs_h0");
    expect_at(7, N_VS, 0, "min_vs_v1"); expect_at(8, N_VS, 1, "min_vs_v2");
    expect_at(8, N_V, 2, "min_v2");     expect_at(10, N_VS, 1, "min_vs_v2e");
    expect_at(11, N_FC, 1, "min_fc1");  expect_at(11, N_FS, 1, "min_fs2");
    expect_at(11, N_VS, 0, "min_vs_f2");
    expect_at(29, N_FC, 3, "min_fc3");  expect_at(37, N_FC, 3, "min_fc3_end");
    expect_at(38, N_FC, 0, "min_fc_wrap"); expect_at(38, N_FS, 1, "min_fs5");

    wait_cyc(258); en_m = 1'b0;
    wait_cyc(400); en_m = 1'b1;
    wait_cyc(465); en_m = 1'b0;
    wait_cyc(529); en_m = 1'b1;

    wait_cyc(683);
    arst_m = 1'b1;
    #1;
    checks++;
    if (m_h !== 4'd0) begin
      errors++; $display("FAIL direct_arst_h: got %0d", m_h);
    end
    checks++;
    if (m_v !== 4'd0) begin
      errors++; $display("FAIL direct_arst_v: got %0d", m_v);
    end
    checks++;
    if (m_fc !== 4'd0) begin
      errors++; $display("FAIL direct_arst_fc: got %0d", m_fc);
    end
    expect_at(683, M_H, 0, "arst_h");   expect_at(683, M_V, 0, "arst_v");
    expect_at(683, M_FC, 0, "arst_fc"); expect_at(683, M_RUN, 0, "arst_run");
    expect_at(683, M_HS, 0, "arst_hs"); expect_at(683, M_FS, 0, "arst_fs");
    wait_cyc(690);
    checks++;
    if (m_run !== 1'b0) begin
      errors++; $display("FAIL direct_held_run: got %0b", m_run);
    end
    arst_m = 1'b0;
    expect_at(690, M_RUN, 0, "rel_run"); expect_at(690, M_H, 0, "rel_h");
    expect_at(691, M_FS, 1, "rel_fs");   expect_at(691, M_H, 0, "rel_h0");
    expect_at(691, M_V, 0, "rel_v0");    expect_at(691, M_RUN, 1, "rel_run1");
    expect_at(691, M_FC, 0, "rel_fc");
    expect_at(692, M_H, 1, "rel_h1");

    wait_cyc(770);
    @(negedge clk);
    #1;
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: never checked (due cyc %0d)", sb[i].name, sb[i].at);
    end
    if (errors == 0) $display("PASS");
    else $display("FAIL");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator, the next generation of the fixed SVGA `display_ctrl`. It produces h/v counters, sync, display-enable and line/frame strobes for any timing set via parameters, with per-signal sync polarity, a run/stop control that only takes effect at frame boundaries, a frame counter, and a configurable output delay line that aligns sync/enable with a pipelined pixel path. It sits between the pixel-clock domain and the game/VGA output register stage.

## Interface
- `H_ACTIVE`, 800: visible pixels per line (≥1)
- `H_FP`, 24: horizontal front porch (≥0)
- `H_SYNC`, 72: horizontal sync width (≥1)
- `H_BP`, 128: horizontal back porch (≥0)
- `V_ACTIVE`, 600: visible lines (≥1)
- `V_FP`, 1; `V_SYNC`, 2; `V_BP`, 22: vertical porches/sync, same rules
- `H_SYNC_POL`, 1; `V_SYNC_POL`, 1: active level of each sync
- `DELAY`, 0: extra pipeline cycles on the `*_d` outputs (0..15)
- `FRAME_CNT_W`, 16: frame counter width
- `pixel_clk`  in  1  pixel clock; the only clock
- `arst`  in  1  reset, asynchronous, active-high
- `en`  in  1  run request, level
- `h_coord`  out  H_W  horizontal count, H_W = $clog2(H_TOTAL)
- `v_coord`  out  V_W  vertical count, V_W = $clog2(V_TOTAL)
- `h_sync`, `v_sync`, `disp_enbl`  out  1 each  undelayed timing, aligned with coords
- `h_sync_d`, `v_sync_d`, `disp_enbl_d`  out  1 each  same, delayed DELAY cycles
- `line_start`, `frame_start`  out  1 each  single-cycle strobes
- `frame_cnt`  out  FRAME_CNT_W  completed-frame count
- `running`  out  1  FSM in RUN

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order: active, front porch, sync, back porch.
- FSM states IDLE, RUN. Reset enters IDLE.
- IDLE: counters held 0; `disp_enbl`=0; syncs at inactive level; strobes 0. If `en`=1, go to RUN. The first RUN cycle shows (0,0).
- RUN: `h_coord` increments each cycle. At H_TOTAL-1 it wraps to 0 and `v_coord` increments. At V_TOTAL-1 with h wrap:
  - if `en`=1, wrap to (0,0) and stay in RUN;
  - else go to IDLE.
  - `en` is sampled only at (H_TOTAL-1, V_TOTAL-1). Deassertion mid-frame never truncates a frame; reassertion before the boundary cancels the stop.
- `disp_enbl` = RUN && h<H_ACTIVE && v<V_ACTIVE.
- `h_sync` active when RUN && H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC. `v_sync` uses the same rule on v, independent of h.
- `line_start` = RUN && h==0. `frame_start` = RUN && h==0 && v==0.
- `frame_cnt` increments, modulo 2^FRAME_CNT_W, on every RUN cycle at (H_TOTAL-1, V_TOTAL-1), whether the next state is RUN or IDLE.
- `*_d` outputs are the undelayed signals passed through a DELAY-stage shift register. DELAY=0 means a combinational pass-through.

## Timing
- Coords, syncs, `disp_enbl`, strobes and `running` are registered and mutually aligned in the same cycle. Decode is computed from the next count value.
- Reset values:
  - coords, `frame_cnt`, strobes, `disp_enbl`, `running`: 0;
  - syncs: !POL;
  - every delay stage: its inactive value (0, or !POL for syncs).
- `arst` asserted mid-frame forces the reset values immediately. After release the block restarts from IDLE.
- Latency from IDLE with `en`=1 to the first `frame_start`: 1 cycle.
- Defaults give a line period of 1024 cycles and a frame of 640000 cycles.

## Structure
- `video_timing_pkg` holds:
  - a `timing_t` struct (active/fp/sync/bp per axis, polarities);
  - constants `SVGA_800X600_56` (defaults above) and `VGA_640X480_60` (640/16/96/48, 480/10/2/33, negative syncs);
  - the FSM state enum.
- Sub-module `sig_delay #(WIDTH, DEPTH, RST_VAL)` implements the delay line; one instance carries all three signals.

## Test plan
- Defaults, `en`=1 from reset:
  - `line_start` every 1024 cycles, `frame_start` every 640000;
  - `h_sync` high for h=824..895, `v_sync` high for v=601..602;
  - `disp_enbl` count per frame = 480000.
- `en` dropped at v=300:
  - frame completes to (1023,624);
  - `frame_cnt` +1, then `running`=0, coords 0, no further strobes;
  - re-raising `en` gives `frame_start` 1 cycle later.
- `en` pulsed low for v=100..200 only: no gap, next `frame_start` exactly 640000 cycles after the previous one.
- `arst` at (500,400):
  - all outputs go to reset values the same cycle, `frame_cnt`=0;
  - after release with `en`=1, (0,0) appears 1 cycle later.
- DELAY=3 with VGA_640X480_60 params:
  - `h_sync_d` equals `h_sync` shifted 3 cycles, active low for h=656..751;
  - `disp_enbl_d` first rises 3 cycles after `frame_start`.
- Minimal params (H 2/0/1/0, V 2/0/1/0, FRAME_CNT_W=2): 3x3 raster, sync at h=2/v=2, `frame_cnt` wraps 3→0 on the 4th frame.
